// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback arbiter.
//   RSTATUS_REG      - register that receives exception status writes ($30)
//   MD_DEPTH_DEFAULT - default depth of the multdiv result FIFO
//   wb_entry_t       - one buffered multdiv result {rd, data}
//   reg_onehot()     - one-hot register mask for a 5-bit register index
package wb_pkg;

  localparam logic [4:0]  RSTATUS_REG      = 5'd30;
  localparam int unsigned MD_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic [31:0] reg_onehot(input logic [4:0] rd);
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_md_fifo.sv
// wb_md_fifo: synchronous FIFO that holds multdiv results until the
// register-file write slot is free.
//   clock, ctrl_reset   - clock and synchronous active-high reset
//   push_i, push_entry_i - enqueue request and entry (dropped while full)
//   pop_i               - dequeue request (ignored while empty)
//   head_o              - oldest entry
//   full_o, empty_o, count_o - occupancy
//   valid_o, rd_o       - per-slot valid bits and destinations
module wb_md_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = MD_DEPTH_DEFAULT,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [AW:0]           count_o,
  output logic [DEPTH-1:0]      valid_o,
  output logic [DEPTH-1:0][4:0] rd_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic             do_push;
  logic             do_pop;

  // Gate requests by occupancy and compute next count and valid vector.
  always_comb begin
    full_o  = (count_q == (AW+1)'(DEPTH));
    empty_o = (count_q == '0);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    valid_d = valid_q;
    if (do_pop) begin
      valid_d[rptr_q] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    if (do_push) begin
      valid_d[wptr_q] = 1'b1;
    end else begin
      valid_d = valid_d;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_entry_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Expose head and per-slot destinations.
  always_comb begin
    head_o  = mem_q[rptr_q];
    count_o = count_q;
    valid_o = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      rd_o[i] = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: owns the register-file write port and merges pipeline
// writebacks, exception status writes and buffered multdiv results.
//   clock, ctrl_reset                    - clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_data               - pipeline writeback (never stalled)
//   exc_valid/exc_code                   - exception status write to RSTATUS_REG
//   md_valid/md_rd/md_data/md_ready      - multdiv result handshake
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg - registered write port
//   pend_mask                            - registers with an outstanding multdiv write
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned MD_DEPTH    = MD_DEPTH_DEFAULT,
  parameter logic [4:0]  RSTATUS_REG = wb_pkg::RSTATUS_REG
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        exc_valid,
  input  logic [31:0] exc_code,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [31:0] pend_mask
);

  localparam int unsigned AW = $clog2(MD_DEPTH);

  wb_entry_t                  fifo_head;
  wb_entry_t                  push_entry;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [AW:0]                fifo_count;
  logic [MD_DEPTH-1:0]        fifo_valid;
  logic [MD_DEPTH-1:0][4:0]   fifo_rd;

  logic        md_keep, exc_sel, wb_sel, slot_free;
  logic        pop_s, byp_s, push_s;
  logic [31:0] fifo_mask;
  logic        we_d, we_q;
  logic [4:0]  wreg_d, wreg_q;
  logic [31:0] wdata_d, wdata_q;
  logic        from_md_d;
  logic [31:0] pend_d, pend_q;

  assign md_ready   = (fifo_count < (AW+1)'(MD_DEPTH));
  assign push_entry = '{rd: md_rd, data: md_data};

  wb_md_fifo #(.DEPTH(MD_DEPTH)) u_fifo (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .push_i       (push_s),
    .push_entry_i (push_entry),
    .pop_i        (pop_s),
    .head_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .valid_o      (fifo_valid),
    .rd_o         (fifo_rd)
  );

  // Slot selection: exception, then pipeline, then FIFO head, then bypass.
  always_comb begin
    // A transfer to $0 is accepted but never stored or written.
    md_keep   = md_valid && md_ready && (md_rd != 5'd0);
    exc_sel   = exc_valid && wb_valid;
    wb_sel    = wb_valid && (wb_rd != 5'd0) && !exc_sel;
    slot_free = !exc_sel && !wb_sel;
    pop_s     = slot_free && !fifo_empty;
    byp_s     = slot_free && fifo_empty && md_keep;
    push_s    = md_keep && !byp_s && !fifo_full;

    we_d      = 1'b0;
    wreg_d    = 5'd0;
    wdata_d   = 32'd0;
    from_md_d = 1'b0;
    if (exc_sel) begin
      we_d    = 1'b1;
      wreg_d  = RSTATUS_REG;
      wdata_d = exc_code;
    end else if (wb_sel) begin
      we_d    = 1'b1;
      wreg_d  = wb_rd;
      wdata_d = wb_data;
    end else if (pop_s) begin
      we_d      = 1'b1;
      wreg_d    = fifo_head.rd;
      wdata_d   = fifo_head.data;
      from_md_d = 1'b1;
    end else if (byp_s) begin
      we_d      = 1'b1;
      wreg_d    = md_rd;
      wdata_d   = md_data;
      from_md_d = 1'b1;
    end else begin
      we_d = 1'b0;
    end

    // Next pending mask: surviving entries plus any new push plus the
    // multdiv write being issued. A popped entry is covered by the write term.
    fifo_mask = 32'd0;
    for (int i = 0; i < MD_DEPTH; i++) begin
      if (fifo_valid[i]) begin
        fifo_mask = fifo_mask | reg_onehot(fifo_rd[i]);
      end else begin
        fifo_mask = fifo_mask;
      end
    end
    pend_d = fifo_mask;
    if (push_s) begin
      pend_d = pend_d | reg_onehot(md_rd);
    end else begin
      pend_d = pend_d;
    end
    if (from_md_d) begin
      pend_d = pend_d | reg_onehot(wreg_d);
    end else begin
      pend_d = pend_d;
    end
  end

  // Registered write port and pending mask.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      we_q    <= 1'b0;
      wreg_q  <= 5'd0;
      wdata_q <= 32'd0;
      pend_q  <= 32'd0;
    end else begin
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign pend_mask        = pend_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  logic        clock;
  logic        ctrl_reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [31:0] exc_code;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [31:0] pend_mask;

  int checks   = 0;
  int failures = 0;

  writeback_arbiter dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .exc_valid        (exc_valid),
    .exc_code         (exc_code),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_ready         (md_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .pend_mask        (pend_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] ec;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [31:0] e_pend;
    logic        e_rdy;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic ev, input logic [31:0] ec,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    wb_valid  = wv;
    wb_rd     = wrd;
    wb_data   = wd;
    exc_valid = ev;
    exc_code  = ec;
    md_valid  = mv;
    md_rd     = mrd;
    md_data   = md;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input logic we, input logic [4:0] rg,
                            input logic [31:0] data, input logic [31:0] pend, input logic rdy);
    chk({name, ".we"},   {31'd0, ctrl_writeEnable}, {31'd0, we});
    chk({name, ".reg"},  {27'd0, ctrl_writeReg},    {27'd0, rg});
    chk({name, ".data"}, data_writeReg,             data);
    chk({name, ".pend"}, pend_mask,                 pend);
    chk({name, ".rdy"},  {31'd0, md_ready},         {31'd0, rdy});
  endtask

  initial begin
    //            wv    wrd    wd            ev    ec     mv    mrd    md             we    reg     data          pend          rdy
    vecs[0]  = '{1'b1, 5'd1,  32'h1111_1111, 1'b0, 32'd0, 1'b0, 5'd0,  32'd0,        1'b1, 5'd1,  32'h1111_1111, 32'h0,      1'b1};
    vecs[1]  = '{1'b1, 5'd4,  32'h0000_AAAA, 1'b1, 32'd1, 1'b0, 5'd0,  32'd0,        1'b1, 5'd30, 32'd1,         32'h0,      1'b1};
    vecs[2]  = '{1'b0, 5'd0,  32'd0,         1'b0, 32'd0, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h20,     1'b1};
    vecs[3]  = '{1'b0, 5'd0,  32'd0,         1'b0, 32'd0, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,         32'h0,      1'b1};
    vecs[4]  = '{1'b1, 5'd2,  32'h22,        1'b0, 32'd0, 1'b1, 5'd7,  32'h77,       1'b1, 5'd2,  32'h22,        32'h80,     1'b1};
    vecs[5]  = '{1'b1, 5'd3,  32'h33,        1'b0, 32'd0, 1'b1, 5'd9,  32'h99,       1'b1, 5'd3,  32'h33,        32'h280,    1'b0};
    vecs[6]  = '{1'b1, 5'd6,  32'h66,        1'b0, 32'd0, 1'b1, 5'd12, 32'hCC,       1'b1, 5'd6,  32'h66,        32'h280,    1'b0};
    vecs[7]  = '{1'b1, 5'd8,  32'h88,        1'b0, 32'd0, 1'b0, 5'd0,  32'd0,        1'b1, 5'd8,  32'h88,        32'h280,    1'b0};
    vecs[8]  = '{1'b0, 5'd0,  32'd0,         1'b0, 32'd0, 1'b0, 5'd0,  32'd0,        1'b1, 5'd7,  32'h77,        32'h280,    1'b1};
    vecs[9]  = '{1'b0, 5'd0,  32'd0,         1'b0, 32'd0, 1'b0, 5'd0,  32'd0,        1'b1, 5'd9,  32'h99,        32'h200,    1'b1};
    vecs[10] = '{1'b0, 5'd0,  32'd0,         1'b0, 32'd0, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,         32'h0,      1'b1};
    vecs[11] = '{1'b0, 5'd0,  32'd0,         1'b0, 32'd0, 1'b1, 5'd0,  32'h5,        1'b0, 5'd0,  32'd0,         32'h0,      1'b1};
    vecs[12] = '{1'b1, 5'd1,  32'h1,         1'b0, 32'd0, 1'b1, 5'd3,  32'h3333_3333, 1'b1, 5'd1, 32'h1,         32'h8,      1'b1};
    vecs[13] = '{1'b1, 5'd0,  32'hBAD,       1'b0, 32'd0, 1'b0, 5'd0,  32'd0,        1'b1, 5'd3,  32'h3333_3333, 32'h8,      1'b1};
    vecs[14] = '{1'b0, 5'd0,  32'd0,         1'b0, 32'd0, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,         32'h0,      1'b1};
    vecs[15] = '{1'b1, 5'd0,  32'h1234,      1'b1, 32'h7, 1'b0, 5'd0,  32'd0,        1'b1, 5'd30, 32'h7,         32'h0,      1'b1};
    vecs[16] = '{1'b0, 5'd0,  32'd0,         1'b1, 32'h9, 1'b1, 5'd10, 32'hA,        1'b1, 5'd10, 32'hA,         32'h400,    1'b1};
    vecs[17] = '{1'b1, 5'd1,  32'h1,         1'b0, 32'd0, 1'b1, 5'd11, 32'hB,        1'b1, 5'd1,  32'h1,         32'h800,    1'b1};
    vecs[18] = '{1'b0, 5'd0,  32'd0,         1'b0, 32'd0, 1'b1, 5'd13, 32'hD,        1'b1, 5'd11, 32'hB,         32'h2800,   1'b1};
    vecs[19] = '{1'b0, 5'd0,  32'd0,         1'b0, 32'd0, 1'b0, 5'd0,  32'd0,        1'b1, 5'd13, 32'hD,         32'h2000,   1'b1};
    vecs[20] = '{1'b0, 5'd0,  32'd0,         1'b0, 32'd0, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,         32'h0,      1'b1};

    // Reset state
    drive(1'b1, 5'd3, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1, 5'd4, 32'hEEEE_EEEE);
    ctrl_reset = 1'b1;
    tick();
    tick();
    expect_out("reset", 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    ctrl_reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    expect_out("post_reset_idle", 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);

    // Table-driven vectors; FIFO state carries from one vector to the next
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].wv, vecs[i].wrd, vecs[i].wd, vecs[i].ev, vecs[i].ec,
            vecs[i].mv, vecs[i].mrd, vecs[i].md);
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_reg,
                 vecs[i].e_data, vecs[i].e_pend, vecs[i].e_rdy);
    end

    // Full boundary: fill with 14,15 while pipeline busy, hold result 16
    drive(1'b1, 5'd1, 32'h1, 1'b0, 32'd0, 1'b1, 5'd14, 32'hE);
    tick();
    expect_out("full_push14", 1'b1, 5'd1, 32'h1, 32'h4000, 1'b1);
    drive(1'b1, 5'd2, 32'h2, 1'b0, 32'd0, 1'b1, 5'd15, 32'hF);
    tick();
    expect_out("full_push15", 1'b1, 5'd2, 32'h2, 32'hC000, 1'b0);
    drive(1'b1, 5'd1, 32'h1, 1'b0, 32'd0, 1'b1, 5'd16, 32'h10);
    tick();
    expect_out("full_hold", 1'b1, 5'd1, 32'h1, 32'hC000, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd16, 32'h10);
    tick();
    expect_out("full_pop14", 1'b1, 5'd14, 32'hE, 32'hC000, 1'b1);
    drive(1'b1, 5'd2, 32'h2, 1'b0, 32'd0, 1'b1, 5'd16, 32'h10);
    tick();
    expect_out("full_accept16", 1'b1, 5'd2, 32'h2, 32'h18000, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    expect_out("full_drain15", 1'b1, 5'd15, 32'hF, 32'h18000, 1'b1);
    tick();
    expect_out("full_drain16", 1'b1, 5'd16, 32'h10, 32'h10000, 1'b1);
    tick();
    expect_out("full_idle", 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);

    // Reset mid-drain: buffer 17,18 then reset with live inputs
    drive(1'b1, 5'd1, 32'h1, 1'b0, 32'd0, 1'b1, 5'd17, 32'h17);
    tick();
    drive(1'b1, 5'd2, 32'h2, 1'b0, 32'd0, 1'b1, 5'd18, 32'h18);
    tick();
    expect_out("rst_filled", 1'b1, 5'd2, 32'h2, 32'h60000, 1'b0);
    drive(1'b1, 5'd5, 32'h55, 1'b0, 32'd0, 1'b1, 5'd19, 32'h19);
    ctrl_reset = 1'b1;
    tick();
    expect_out("rst_mid", 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    ctrl_reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("rst_after%0d", k), 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
